// File: rtl/alu_slice_sequencer.sv
// rtl/alu_slice_sequencer.sv - 16-bit request sequenced as two 8-bit ALU slice beats, carry chained lo->hi.
module alu_slice_sequencer #(
    parameter int TIMEOUT_CYC = 500,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [2:0]  req_op,
    output logic        slice_valid,
    output logic [7:0]  slice_a,
    output logic [7:0]  slice_b,
    output logic [2:0]  slice_op,
    output logic        slice_cin,
    output logic        slice_hi,
    input  logic        slice_ack,
    input  logic [7:0]  slice_res,
    input  logic        slice_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MAX = 3'd4;

    logic [1:0]  state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] res_q, res_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        is_arith;
    logic        tmo_hit;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

`ifdef SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE || (slice_valid && slice_ack)) begin
            cnt_d = '0;
        end else if (slice_valid) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tmo_hit = slice_valid && !slice_ack && (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    res_d   = 16'd0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    if (req_op > OP_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (slice_ack) begin
                    res_d[7:0] = slice_res;
                    carry_d    = slice_cout;
                    state_d    = S_HI;
                end else if (tmo_hit) begin
                    res_d   = 16'd0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_HI: begin
                if (slice_ack) begin
                    res_d[15:8] = slice_res;
                    if (op_q == OP_ADD) begin
                        ovf_d = (a_q[15] == b_q[15]) && (slice_res[7] != a_q[15]);
                    end else if (op_q == OP_SUB) begin
                        ovf_d = (a_q[15] != b_q[15]) && (slice_res[7] != a_q[15]);
                    end else begin
                        ovf_d = 1'b0;
                    end
                    state_d = S_RSP;
                end else if (tmo_hit) begin
                    res_d   = 16'd0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RSP;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            op_q    <= 3'd0;
            res_q   <= 16'd0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign slice_valid = (state_q == S_LO) || (state_q == S_HI);
    assign slice_hi    = (state_q == S_HI);
    assign slice_a     = slice_hi ? a_q[15:8] : a_q[7:0];
    assign slice_b     = slice_hi ? b_q[15:8] : b_q[7:0];
    assign slice_op    = op_q;
    assign slice_cin   = (state_q == S_LO) ? (op_q == OP_SUB) :
                         (state_q == S_HI) ? (is_arith && carry_q) : 1'b0;
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_result  = res_q;
    assign rsp_ovf     = ovf_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb/tb_alu_slice_sequencer.sv - directed vectors and corner sequences for alu_slice_sequencer.
module tb_alu_slice_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [2:0]  req_op;
    logic        slice_valid;
    logic [7:0]  slice_a;
    logic [7:0]  slice_b;
    logic [2:0]  slice_op;
    logic        slice_cin;
    logic        slice_hi;
    logic        slice_ack;
    logic [7:0]  slice_res;
    logic        slice_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_ovf;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_slice_sequencer #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .slice_valid(slice_valid), .slice_a(slice_a), .slice_b(slice_b),
        .slice_op(slice_op), .slice_cin(slice_cin), .slice_hi(slice_hi),
        .slice_ack(slice_ack), .slice_res(slice_res), .slice_cout(slice_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    int   ack_delay;
    logic ack_en;
    int   wcnt = 0;
    int   sv_cycles = 0;
    logic [8:0] alu_sum;

    always_comb begin
        alu_sum = 9'd0;
        case (slice_op)
            3'd0: alu_sum = {1'b0, slice_a} + {1'b0, slice_b} + {8'd0, slice_cin};
            3'd1: alu_sum = {1'b0, slice_a} + {1'b0, ~slice_b} + {8'd0, slice_cin};
            3'd2: alu_sum = {1'b0, slice_a & slice_b};
            3'd3: alu_sum = {1'b0, slice_a | slice_b};
            3'd4: alu_sum = {1'b0, slice_a ^ slice_b};
            default: alu_sum = 9'd0;
        endcase
    end

    assign slice_res  = alu_sum[7:0];
    assign slice_cout = alu_sum[8];
    assign slice_ack  = ack_en && slice_valid && (wcnt >= ack_delay);

    always @(posedge clk) begin
        wcnt <= (!slice_valid || slice_ack) ? 0 : wcnt + 1;
        if (slice_valid) sv_cycles <= sv_cycles + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic ovf, output logic err,
                           output int lat);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
        end
        res = rsp_result; ovf = rsp_ovf; err = rsp_err;
        step();
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [15:0] r;
        logic o, e;
        int   lat;
        int   sv0;

        vecs[0]  = '{3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 3};
        vecs[1]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 3};
        vecs[2]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 3};
        vecs[3]  = '{3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 3};
        vecs[4]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 3};
        vecs[5]  = '{3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 3};
        vecs[6]  = '{3'd1, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0, 3};
        vecs[7]  = '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 3};
        vecs[8]  = '{3'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0, 3};
        vecs[9]  = '{3'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 3};
        vecs[10] = '{3'd5, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1};
        vecs[11] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1};

        rst_n = 1'b0; req_valid = 1'b0; req_a = 16'd0; req_b = 16'd0; req_op = 3'd0;
        rsp_ready = 1'b0; ack_delay = 0; ack_en = 1'b1;
        repeat (2) step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_slice_valid", slice_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_ovf_err", {rsp_ovf, rsp_err}, 0);
        chk("rst_slice_a_b_hi", {slice_a, slice_b, slice_hi, slice_cin}, 0);
        rst_n = 1'b1;
        step();

        req_op = 3'd0; req_a = 16'h00FF; req_b = 16'h0001; req_valid = 1'b1; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("s1_lo_valid", slice_valid, 1);
        chk("s1_lo_hi", slice_hi, 0);
        chk("s1_lo_ab", {slice_a, slice_b}, 16'hFF01);
        chk("s1_lo_cin", slice_cin, 0);
        chk("s1_lo_req_ready", req_ready, 0);
        step();
        chk("s1_hi_valid_hi", {slice_valid, slice_hi}, 2'b11);
        chk("s1_hi_ab", {slice_a, slice_b}, 16'h0000);
        chk("s1_hi_cin", slice_cin, 1);
        step();
        chk("s1_rsp_valid_c3", rsp_valid, 1);
        chk("s1_rsp_result", rsp_result, 16'h0100);
        chk("s1_rsp_ovf_err", {rsp_ovf, rsp_err}, 0);
        step();
        chk("s1_idle_c4", {req_ready, rsp_valid}, 2'b10);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, r, o, e, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
            chk($sformatf("vec%0d_err", i), e, vecs[i].err);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_idle", i), req_ready, 1);
        end

        ack_delay = 3;
        req_op = 3'd1; req_a = 16'h8000; req_b = 16'h0001; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("s2_lo_c%0d", c), {slice_valid, slice_hi, slice_cin, slice_a, slice_b},
                {3'b101, 16'h0001});
            step();
        end
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("s2_hi_c%0d", c), {slice_valid, slice_hi, slice_cin, slice_a, slice_b},
                {3'b110, 16'h8000});
            step();
        end
        chk("s2_rsp_valid", rsp_valid, 1);
        chk("s2_rsp", {rsp_result, rsp_ovf, rsp_err}, {16'h7FFF, 2'b10});
        step();
        ack_delay = 0;

        rsp_ready = 1'b0;
        req_op = 3'd0; req_a = 16'h7FFF; req_b = 16'h0001; req_valid = 1'b1;
        step();
        req_valid = 1'b1;
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("s3_hold_c%0d", c), {rsp_valid, req_ready, rsp_result, rsp_ovf, rsp_err},
                {2'b10, 16'h8000, 2'b10});
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("s3_still_valid", rsp_valid, 1);
        step();
        chk("s3_release", {rsp_valid, req_ready}, 2'b01);

        req_op = 3'd4; req_a = 16'hF0F0; req_b = 16'h0FF0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("s4_hi_cin", {slice_hi, slice_cin}, 2'b10);
        step();
        chk("s4_xor", {rsp_valid, rsp_result, rsp_ovf, rsp_err}, {1'b1, 16'hFF00, 2'b00});
        step();
        sv0 = sv_cycles;
        run_txn(3'd6, 16'hAAAA, 16'h5555, r, o, e, lat);
        chk("s4_op6_no_slice", sv_cycles - sv0, 0);
        chk("s4_op6_rsp", {r, o, e}, {16'h0000, 2'b01});

        req_op = 3'd0; req_a = 16'h00FF; req_b = 16'h0001; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        ack_en = 1'b0;
        chk("s5_in_hi", {slice_valid, slice_hi}, 2'b11);
        rst_n = 1'b0;
        step();
        chk("s5_after_rst", {slice_valid, rsp_valid, req_ready}, 3'b001);
        rst_n = 1'b1;
        ack_en = 1'b1;
        step();
        run_txn(3'd0, 16'h1234, 16'h1111, r, o, e, lat);
        chk("s5_new_add", {r, o, e}, {16'h2345, 2'b00});
        chk("s5_new_latency", lat, 3);

`ifdef SEQ_TIMEOUT_EN
        ack_en = 1'b0;
        sv0 = sv_cycles;
        run_txn(3'd0, 16'h0001, 16'h0002, r, o, e, lat);
        chk("s6_valid_cycles", sv_cycles - sv0, 8);
        chk("s6_tmo_rsp", {r, o, e}, {16'h0000, 2'b01});
        ack_en = 1'b1;
        ack_delay = 7;
        step();
        run_txn(3'd0, 16'h0001, 16'h0002, r, o, e, lat);
        chk("s6_last_cycle_ack", {r, o, e}, {16'h0003, 2'b00});
        chk("s6_last_cycle_latency", lat, 17);
        ack_delay = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
